pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 2, number of cycles squashed after a taken branch (legal range 1..7).
REQ-002 Parameter: CNT_WIDTH, default 8, width of the hazard-cycle counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous and active-low.
REQ-005 id_valid  in  1  instruction present at the decode-register inputs.
REQ-006 id_opcode  in  7  opcode of the decoding instruction.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  source and destination register indices.
REQ-008 branch_taken  in  1  single-cycle pulse from execute: redirect taken.
REQ-009 stall_if  out  1  hold PC/fetch register.
REQ-010 stall_id  out  1  hold the decode/execute pipeline register inputs.
REQ-011 bubble_ex  out  1  load a NOP (opcode 0000000, rd 0) into the execute register.
REQ-012 flush_id  out  1  invalidate the instruction currently in decode.
REQ-013 fwd_a, fwd_b  out  2 each  operand source for the EX instruction: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage result, 11 unused.
REQ-014 hazard_cnt  out  CNT_WIDTH  count of cycles spent stalled or flushing.

Function
REQ-015 Decode classes: load 0000011; writes rd for opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111; uses rs1 for all opcodes except 0110111, 0010111, 1101111; uses rs2 only for 0110011, 0100011, 1100011.
REQ-016 Three shadow slots EX, MEM, WB each hold {valid, rd, is_load}; each cycle WB<=MEM, MEM<=EX, EX<=decoded ID instruction, or EX<=invalid when bubble_ex=1.
REQ-017 A slot whose rd is 0, or whose instruction does not write rd, is stored as valid=0.
REQ-018 Load-use hazard = id_valid AND EX.valid AND EX.is_load AND ((uses_rs1 AND EX.rd==id_rs1) OR (uses_rs2 AND EX.rd==id_rs2)).
REQ-019 FSM states RUN and FLUSH; reset state RUN.
REQ-020 RUN: on a load-use hazard with no branch_taken, assert stall_if, stall_id and bubble_ex combinationally in that cycle only; the FSM remains in RUN.
REQ-021 RUN or FLUSH: branch_taken=1 loads the flush counter with FLUSH_CYCLES-1 and enters FLUSH; flush_id and bubble_ex assert in that same cycle; stall_if stays 0.
REQ-022 FLUSH: assert flush_id and bubble_ex every cycle; decrement the counter; at counter 0 with no branch_taken, return to RUN next cycle.
REQ-023 Priority: branch_taken > FLUSH activity > load-use; load-use detection is ignored while in FLUSH.
REQ-024 Forwarding is computed in ID and registered into fwd_a/fwd_b when the EX slot is loaded.
REQ-025 Forwarding select per operand: 01 if EX.valid and EX.rd matches the source; else 10 if MEM.valid and MEM.rd matches the source; else 00.
REQ-026 An unused operand gets select 00.
REQ-027 A bubble loads 00 into both fwd_a and fwd_b.
REQ-028 hazard_cnt increments by 1 each cycle in which stall_id or flush_id is 1, and saturates at all-ones.
REQ-029 With id_valid=0: no load-use hazard is raised, and EX is loaded as invalid.

Reset
REQ-030 rst_n=0 at a clock edge forces: FSM to RUN, flush counter to 0, all slot valids to 0, fwd_a/fwd_b to 00, and hazard_cnt to 0.
REQ-031 During reset, stall_if, stall_id, bubble_ex and flush_id are all 0.
REQ-032 Reset asserted mid-FLUSH or mid-stall abandons the operation; the first cycle after release is normal RUN.

Structure
REQ-033 The opcode constants, forwarding-select encodings and FSM state encoding shall live in a shared package, pipe_pkg.
REQ-034 One sub-module, pipe_op_decode (combinational: opcode -> is_load, writes_rd, uses_rs1, uses_rs2), shall be instantiated once for the ID instruction.

Verification
REQ-035 lw x5,0(x1) followed by add x6,x5,x2 -> exactly one cycle with stall_if=stall_id=bubble_ex=1; add then enters EX with fwd_a=10, fwd_b=00; hazard_cnt=1.
REQ-036 addi x5 followed by add x6,x5,x5 -> no stall; fwd_a=01 and fwd_b=01.
REQ-037 branch_taken pulse with FLUSH_CYCLES=2 -> flush_id=bubble_ex=1 for exactly 2 cycles, then RUN; hazard_cnt+=2.
REQ-038 branch_taken in the same cycle as a load-use hazard -> stall_if=0 and flush path taken; branch_taken again in the 2nd FLUSH cycle -> flush extended to 3 cycles total.
REQ-039 lw x0 followed by a user of x0 -> no stall, fwd 00; lui after a load to the same rd -> no stall.
REQ-040 rst_n=0 in the 1st FLUSH cycle -> all outputs 0 next cycle; after release, a load-use pair stalls exactly 1 cycle; force 300 stall cycles -> hazard_cnt holds at 255.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Opcode, forwarding-select and FSM encodings for the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;

    localparam logic [1:0] c_fwd_rf  = 2'b00;
    localparam logic [1:0] c_fwd_mem = 2'b01;
    localparam logic [1:0] c_fwd_wb  = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    // The EX slot will sit in MEM when the consumer reaches EX, hence 01 for an EX match.
    function automatic logic [1:0] fwd_sel(
        input logic       uses,
        input logic [4:0] src,
        input slot_t      ex,
        input slot_t      mem
    );
        if (!uses)                          return c_fwd_rf;
        if (ex.valid && (ex.rd == src))     return c_fwd_mem;
        if (mem.valid && (mem.rd == src))   return c_fwd_wb;
        return c_fwd_rf;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl_if
// Description : Decode-stage inputs and hazard/forwarding controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 id_valid;
    logic [6:0]           id_opcode;
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic [4:0]           id_rd;
    logic                 branch_taken;
    logic                 stall_if;
    logic                 stall_id;
    logic                 bubble_ex;
    logic                 flush_id;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;
    logic [CNT_WIDTH-1:0] hazard_cnt;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, branch_taken,
        input  stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, hazard_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, branch_taken,
        output stall_if, stall_id, bubble_ex, flush_id, fwd_a, fwd_b, hazard_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : pipe_op_decode
// Description : Opcode classifier for register usage and load detection.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_op_decode (
    input  logic [6:0] i_opcode,
    output logic       o_is_load,
    output logic       o_writes_rd,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2
);
    import pipe_pkg::*;

    always_comb begin
        o_is_load   = (i_opcode == c_op_load);
        o_writes_rd = i_opcode inside {c_op_op, c_op_imm, c_op_load, c_op_lui,
                                       c_op_auipc, c_op_jal, c_op_jalr};
        o_uses_rs1  = !(i_opcode inside {c_op_lui, c_op_auipc, c_op_jal});
        o_uses_rs2  = i_opcode inside {c_op_op, c_op_store, c_op_branch};
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Load-use stall, branch flush and operand forwarding control.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    import pipe_pkg::*;

    localparam logic [2:0]           c_flush_reload = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max      = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [2:0]           r_flush_cnt;
    slot_t                r_ex;
    slot_t                r_mem;
    slot_t                r_wb;
    logic [1:0]           r_fwd_a;
    logic [1:0]           r_fwd_b;
    logic [CNT_WIDTH-1:0] r_hazard_cnt;

    logic                 w_is_load;
    logic                 w_writes_rd;
    logic                 w_uses_rs1;
    logic                 w_uses_rs2;
    logic                 w_load_use;
    logic                 w_flush;
    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_id_live;
    slot_t                w_ex_next;
    logic [1:0]           w_fwd_a;
    logic [1:0]           w_fwd_b;
    logic                 w_unused;

    pipe_op_decode u_id_decode (
        .i_opcode    (hz.id_opcode),
        .o_is_load   (w_is_load),
        .o_writes_rd (w_writes_rd),
        .o_uses_rs1  (w_uses_rs1),
        .o_uses_rs2  (w_uses_rs2)
    );

    always_comb begin
        w_load_use = hz.id_valid && r_ex.valid && r_ex.is_load &&
                     ((w_uses_rs1 && (r_ex.rd == hz.id_rs1)) ||
                      (w_uses_rs2 && (r_ex.rd == hz.id_rs2)));
        // Branch and flush win over load-use; everything is quiet while in reset.
        w_flush   = rst_n && (hz.branch_taken || (r_state == ST_FLUSH));
        w_stall   = rst_n && !w_flush && w_load_use;
        w_bubble  = w_flush || w_stall;
        w_id_live = hz.id_valid && !w_bubble;

        w_ex_next.valid   = w_id_live && w_writes_rd && (hz.id_rd != 5'd0);
        w_ex_next.rd      = hz.id_rd;
        w_ex_next.is_load = w_is_load;

        w_fwd_a = w_id_live ? fwd_sel(w_uses_rs1, hz.id_rs1, r_ex, r_mem) : c_fwd_rf;
        w_fwd_b = w_id_live ? fwd_sel(w_uses_rs2, hz.id_rs2, r_ex, r_mem) : c_fwd_rf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_flush_cnt  <= 3'd0;
            r_ex         <= '0;
            r_mem        <= '0;
            r_wb         <= '0;
            r_fwd_a      <= c_fwd_rf;
            r_fwd_b      <= c_fwd_rf;
            r_hazard_cnt <= '0;
        end else begin
            r_wb    <= r_mem;
            r_mem   <= r_ex;
            r_ex    <= w_ex_next;
            r_fwd_a <= w_fwd_a;
            r_fwd_b <= w_fwd_b;

            // The branch cycle itself is the first squashed cycle.
            if (hz.branch_taken) begin
                r_flush_cnt <= c_flush_reload;
                r_state     <= (c_flush_reload != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (r_state == ST_FLUSH) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
                if (r_flush_cnt <= 3'd1) begin
                    r_state <= ST_RUN;
                end
            end

            if (w_bubble && (r_hazard_cnt != c_cnt_max)) begin
                r_hazard_cnt <= r_hazard_cnt + c_cnt_one;
            end
        end
    end

    assign hz.stall_if   = w_stall;
    assign hz.stall_id   = w_stall;
    assign hz.bubble_ex  = w_bubble;
    assign hz.flush_id   = w_flush;
    assign hz.fwd_a      = r_fwd_a;
    assign hz.fwd_b      = r_fwd_b;
    assign hz.hazard_cnt = r_hazard_cnt;

    assign w_unused = ^r_wb;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed and randomized checks of the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int FC     = 2;
    localparam int CW     = 8;
    localparam int CNTMAX = (1 << CW) - 1;

    localparam bit [6:0] OP_LOAD  = 7'b0000011;
    localparam bit [6:0] OP_STORE = 7'b0100011;
    localparam bit [6:0] OP_BR    = 7'b1100011;
    localparam bit [6:0] OP_OP    = 7'b0110011;
    localparam bit [6:0] OP_IMM   = 7'b0010011;
    localparam bit [6:0] OP_LUI   = 7'b0110111;
    localparam bit [6:0] OP_AUIPC = 7'b0010111;
    localparam bit [6:0] OP_JAL   = 7'b1101111;
    localparam bit [6:0] OP_JALR  = 7'b1100111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       t_valid = 1'b0;
    logic [6:0] t_op    = 7'd0;
    logic [4:0] t_rs1   = 5'd0;
    logic [4:0] t_rs2   = 5'd0;
    logic [4:0] t_rd    = 5'd0;
    logic       t_br    = 1'b0;

    pipe_hazard_ctrl_if #(.CNT_WIDTH(CW)) hz ();

    assign hz.id_valid     = t_valid;
    assign hz.id_opcode    = t_op;
    assign hz.id_rs1       = t_rs1;
    assign hz.id_rs2       = t_rs2;
    assign hz.id_rd        = t_rd;
    assign hz.branch_taken = t_br;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: history of the last two instructions that entered EX.
    typedef struct { bit v; bit [4:0] rd; bit ld; } ent_t;
    ent_t     m_hist[2];
    int       m_flush_left = 0;
    int       m_cnt        = 0;
    bit [1:0] m_fa         = 2'b00;
    bit [1:0] m_fb         = 2'b00;
    bit       e_stall;
    bit       e_flush;

    function automatic bit m_writes(bit [6:0] op);
        return op inside {OP_OP, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};
    endfunction
    function automatic bit m_uses1(bit [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction
    function automatic bit m_uses2(bit [6:0] op);
        return op inside {OP_OP, OP_STORE, OP_BR};
    endfunction
    function automatic bit [1:0] m_fwd(bit used, bit [4:0] src);
        if (!used) return 2'b00;
        if (m_hist[0].v && m_hist[0].rd == src) return 2'b01;
        if (m_hist[1].v && m_hist[1].rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic void model_eval();
        bit lu;
        lu = t_valid && m_hist[0].v && m_hist[0].ld &&
             ((m_uses1(t_op) && m_hist[0].rd == t_rs1) || (m_uses2(t_op) && m_hist[0].rd == t_rs2));
        e_flush = rst_n && (t_br || m_flush_left > 0);
        e_stall = rst_n && !e_flush && lu;
    endfunction

    function automatic void model_commit();
        bit   bub;
        ent_t n;
        model_eval();
        if (!rst_n) begin
            m_hist[0] = '{0, 0, 0};
            m_hist[1] = '{0, 0, 0};
            m_flush_left = 0;
            m_cnt = 0;
            m_fa = 2'b00;
            m_fb = 2'b00;
            return;
        end
        bub = e_flush || e_stall;
        if (bub && m_cnt < CNTMAX) m_cnt++;
        m_fa = (bub || !t_valid) ? 2'b00 : m_fwd(m_uses1(t_op), t_rs1);
        m_fb = (bub || !t_valid) ? 2'b00 : m_fwd(m_uses2(t_op), t_rs2);
        n.v  = !bub && t_valid && m_writes(t_op) && t_rd != 0;
        n.rd = t_rd;
        n.ld = (t_op == OP_LOAD);
        m_hist[1] = m_hist[0];
        m_hist[0] = n;
        if (t_br) m_flush_left = FC - 1;
        else if (m_flush_left > 0) m_flush_left--;
    endfunction

    task automatic set_in(input bit v, input bit [6:0] op, input bit [4:0] r1,
                          input bit [4:0] r2, input bit [4:0] rd, input bit br);
        t_valid = v; t_op = op; t_rs1 = r1; t_rs2 = r2; t_rd = rd; t_br = br;
    endtask

    task automatic to_neg();
        @(negedge clk);
        model_eval();
    endtask

    task automatic to_pos();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_in(1, OP_OP, 1, 2, 3, 1);
        to_neg();
        checks++; if (hz.flush_id !== 1'b0) begin failures++; $display("FAIL rst_flush_id got=%b exp=0", hz.flush_id); end
        checks++; if (hz.bubble_ex !== 1'b0) begin failures++; $display("FAIL rst_bubble_ex got=%b exp=0", hz.bubble_ex); end
        checks++; if (hz.stall_if !== 1'b0 || hz.stall_id !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b%b exp=00", hz.stall_if, hz.stall_id); end
        to_pos();
        to_pos();
        checks++; if (hz.fwd_a !== 2'b00 || hz.fwd_b !== 2'b00) begin failures++; $display("FAIL rst_fwd got=%b/%b exp=00/00", hz.fwd_a, hz.fwd_b); end
        checks++; if (hz.hazard_cnt !== 8'd0) begin failures++; $display("FAIL rst_hazard_cnt got=%0d exp=0", hz.hazard_cnt); end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        to_neg();
        to_pos();
    endtask

    task automatic test_load_use();
        set_in(1, OP_LOAD, 1, 0, 5, 0);
        to_neg();
        checks++; if (hz.stall_id !== 1'b0) begin failures++; $display("FAIL lu_first_stall got=%b exp=0", hz.stall_id); end
        to_pos();
        set_in(1, OP_OP, 5, 2, 6, 0);
        to_neg();
        checks++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id} !== 4'b1110) begin
            failures++; $display("FAIL lu_stall got=%b exp=1110", {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id}); end
        to_pos();
        checks++; if (hz.fwd_a !== 2'b00) begin failures++; $display("FAIL lu_bubble_fwd got=%b exp=00", hz.fwd_a); end
        to_neg();
        checks++; if (hz.stall_id !== 1'b0) begin failures++; $display("FAIL lu_single_stall got=%b exp=0", hz.stall_id); end
        to_pos();
        checks++; if (hz.fwd_a !== 2'b10 || hz.fwd_b !== 2'b00) begin failures++; $display("FAIL lu_fwd got=%b/%b exp=10/00", hz.fwd_a, hz.fwd_b); end
        checks++; if (hz.hazard_cnt !== 8'd1) begin failures++; $display("FAIL lu_hazard_cnt got=%0d exp=1", hz.hazard_cnt); end
    endtask

    task automatic test_ex_forward();
        set_in(1, OP_IMM, 1, 0, 5, 0);
        to_neg(); to_pos();
        set_in(1, OP_OP, 5, 5, 6, 0);
        to_neg();
        checks++; if (hz.stall_id !== 1'b0) begin failures++; $display("FAIL exf_stall got=%b exp=0", hz.stall_id); end
        to_pos();
        checks++; if (hz.fwd_a !== 2'b01 || hz.fwd_b !== 2'b01) begin failures++; $display("FAIL exf_fwd got=%b/%b exp=01/01", hz.fwd_a, hz.fwd_b); end
    endtask

    task automatic test_branch_flush();
        int base;
        int nflush;
        base = m_cnt;
        nflush = 0;
        set_in(0, 0, 0, 0, 0, 1);
        to_neg();
        checks++; if (hz.stall_if !== 1'b0 || hz.bubble_ex !== 1'b1) begin failures++; $display("FAIL br_first got=%b%b exp=01", hz.stall_if, hz.bubble_ex); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) to_neg();
            if (hz.flush_id === 1'b1) nflush++;
            to_pos();
            set_in(1, OP_IMM, 1, 0, 3, 0);
        end
        checks++; if (nflush != FC) begin failures++; $display("FAIL br_flush_len got=%0d exp=%0d", nflush, FC); end
        checks++; if (int'(hz.hazard_cnt) != base + FC) begin failures++; $display("FAIL br_hazard_cnt got=%0d exp=%0d", hz.hazard_cnt, base + FC); end
    endtask

    task automatic test_branch_over_loaduse();
        int nflush;
        nflush = 0;
        set_in(1, OP_LOAD, 1, 0, 7, 0);
        to_neg(); to_pos();
        set_in(1, OP_OP, 7, 0, 8, 1);
        to_neg();
        checks++; if (hz.stall_if !== 1'b0 || hz.flush_id !== 1'b1 || hz.bubble_ex !== 1'b1) begin
            failures++; $display("FAIL brlu got=%b%b%b exp=011", hz.stall_if, hz.flush_id, hz.bubble_ex); end
        nflush++;
        to_pos();
        set_in(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            to_neg();
            if (hz.flush_id === 1'b1) nflush++;
            to_pos();
            set_in(0, 0, 0, 0, 0, 0);
        end
        checks++; if (nflush != 3) begin failures++; $display("FAIL brlu_extend got=%0d exp=3", nflush); end
    endtask

    task automatic test_x0_and_lui();
        set_in(1, OP_LOAD, 1, 0, 0, 0);
        to_neg(); to_pos();
        set_in(1, OP_OP, 0, 0, 6, 0);
        to_neg();
        checks++; if (hz.stall_id !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", hz.stall_id); end
        to_pos();
        checks++; if (hz.fwd_a !== 2'b00 || hz.fwd_b !== 2'b00) begin failures++; $display("FAIL x0_fwd got=%b/%b exp=00/00", hz.fwd_a, hz.fwd_b); end
        set_in(1, OP_LOAD, 2, 0, 9, 0);
        to_neg(); to_pos();
        set_in(1, OP_LUI, 9, 9, 9, 0);
        to_neg();
        checks++; if (hz.stall_id !== 1'b0) begin failures++; $display("FAIL lui_stall got=%b exp=0", hz.stall_id); end
        to_pos();
    endtask

    task automatic test_reset_mid_flush();
        int nstall;
        nstall = 0;
        set_in(0, 0, 0, 0, 0, 1);
        to_neg(); to_pos();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        to_neg();
        checks++; if (hz.flush_id !== 1'b0) begin failures++; $display("FAIL rmf_in_reset got=%b exp=0", hz.flush_id); end
        to_pos();
        rst_n = 1'b1;
        to_neg();
        checks++; if ({hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id} !== 4'b0000) begin
            failures++; $display("FAIL rmf_after got=%b exp=0000", {hz.stall_if, hz.stall_id, hz.bubble_ex, hz.flush_id}); end
        checks++; if (hz.hazard_cnt !== 8'd0 || hz.fwd_a !== 2'b00) begin failures++; $display("FAIL rmf_regs got=%0d/%b exp=0/00", hz.hazard_cnt, hz.fwd_a); end
        to_pos();
        set_in(1, OP_LOAD, 1, 0, 4, 0);
        to_neg(); to_pos();
        set_in(1, OP_STORE, 3, 4, 0, 0);
        for (int i = 0; i < 3; i++) begin
            to_neg();
            if (hz.stall_id === 1'b1) nstall++;
            to_pos();
        end
        checks++; if (nstall != 1) begin failures++; $display("FAIL rmf_loaduse got=%0d exp=1", nstall); end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        set_in(1, OP_LOAD, 5, 0, 5, 0);
        for (int i = 0; i < 600; i++) begin
            to_neg();
            if (hz.stall_id !== e_stall) bad++;
            to_pos();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL sat_stall_pattern got=%0d exp=0", bad); end
        checks++; if (hz.hazard_cnt !== 8'd255) begin failures++; $display("FAIL sat_hazard_cnt got=%0d exp=255", hz.hazard_cnt); end
        set_in(0, 0, 0, 0, 0, 0);
        to_neg(); to_pos();
    endtask

    task automatic test_random();
        bit [6:0] ops[10];
        ops = '{OP_LOAD, OP_LOAD, OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_STORE, OP_BR};
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            set_in($urandom_range(0, 4) != 0,
                   ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 9) == 0);
            to_neg();
            checks++; if (hz.stall_if !== e_stall || hz.stall_id !== e_stall) begin
                failures++; $display("FAIL rnd_stall cyc=%0d got=%b%b exp=%b", i, hz.stall_if, hz.stall_id, e_stall); end
            checks++; if (hz.flush_id !== e_flush || hz.bubble_ex !== (e_flush | e_stall)) begin
                failures++; $display("FAIL rnd_flush cyc=%0d got=%b%b exp=%b%b", i, hz.flush_id, hz.bubble_ex, e_flush, e_flush | e_stall); end
            to_pos();
            checks++; if (hz.fwd_a !== m_fa || hz.fwd_b !== m_fb) begin
                failures++; $display("FAIL rnd_fwd cyc=%0d got=%b/%b exp=%b/%b", i, hz.fwd_a, hz.fwd_b, m_fa, m_fb); end
            checks++; if (int'(hz.hazard_cnt) != m_cnt) begin
                failures++; $display("FAIL rnd_hazard_cnt cyc=%0d got=%0d exp=%0d", i, hz.hazard_cnt, m_cnt); end
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_hist[0] = '{0, 0, 0};
        m_hist[1] = '{0, 0, 0};
        test_reset();
        test_load_use();
        test_ex_forward();
        test_branch_flush();
        test_branch_over_loaduse();
        test_x0_and_lui();
        test_reset_mid_flush();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
